// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the PUF response packer.
// Build option: PUF_PACKER_TAG_EN reserves the top TAG_SZ data bits for the word index.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

`ifdef PUF_PACKER_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  localparam int DATA_SZ_DEF = 264;
  localparam int TAG_SZ_DEF  = 8;

  function automatic int payload_bits(input int data_sz, input int tag_sz);
    return data_sz - (TAG_EN ? tag_sz : 0);
  endfunction

  function automatic int cnt_width(input int data_sz);
    return $clog2(data_sz + 1);
  endfunction

  localparam int PAYLOAD   = payload_bits(DATA_SZ_DEF, TAG_SZ_DEF);
  localparam int BIT_CNT_W = cnt_width(DATA_SZ_DEF);

endpackage

// File: rtl/puf_resp_packer.sv
// Packs the serial PUF response bit stream into memory words at consecutive addresses.
// Build option: PUF_PACKER_TAG_EN places the word index in data_in[DATA_SZ-1 -: TAG_SZ].
module puf_resp_packer
  import puf_pkg::*;
#(
  parameter int ADDR_SZ   = 8,
  parameter int DATA_SZ   = 264,
  parameter int NUM_WORDS = 8,
  parameter int TAG_SZ    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               write_en,
  output logic [ADDR_SZ-1:0] addr,
  output logic [DATA_SZ-1:0] data_in,
  output logic               busy,
  output logic               done
);

  localparam int                 PLD       = payload_bits(DATA_SZ, TAG_SZ);
  localparam int                 CNT_W     = cnt_width(DATA_SZ);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(PLD - 1);
  localparam logic [ADDR_SZ-1:0] LAST_WORD = ADDR_SZ'(NUM_WORDS - 1);

  state_e             state_q, state_d;
  logic [PLD-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_SZ-1:0] word_idx_q, word_idx_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [DATA_SZ-1:0] data_q, data_d;
  logic               we_q, we_d;
  logic [PLD-1:0]     word;

  // Next-state logic: shift bits in MSB-first so the first accepted bit ends at bit 0.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    word       = sr_q >> 1;
    word[PLD-1] = bit_in;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = COLLECT;
          bit_cnt_d  = '0;
          word_idx_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          sr_d = word;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = WRITE;
            bit_cnt_d = '0;
            we_d      = 1'b1;
            addr_d    = word_idx_q;
`ifdef PUF_PACKER_TAG_EN
            data_d    = {TAG_SZ'(word_idx_q), word};
`else
            data_d    = word;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          sr_d = sr_q;
        end
      end
      WRITE: begin
        if (word_idx_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          state_d    = COLLECT;
          word_idx_d = word_idx_q + ADDR_SZ'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  assign bit_ready = (state_q == COLLECT);
  assign busy      = (state_q == COLLECT) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign write_en  = we_q;
  assign addr      = addr_q;
  assign data_in   = data_q;

endmodule
